// File: rtl/input_pkg.sv
// Shared types for the input-conditioning blocks: per-channel button FSM
// state and the counter-width helper.
package input_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } btn_state_e;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioner channel: tick-driven debounce plus RELEASED/PRESSED/LONG
// event FSM. Auto-repeat is present only when AUTO_REPEAT_EN is defined.
module button_channel
    import input_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 200,
    parameter int LONG_TICKS     = 2000,
    parameter int REPEAT_TICKS   = 400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       s,
    output logic       level,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output btn_state_e state_dbg
);

    if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
        $error("button_channel: DEBOUNCE_TICKS must be >= 1");
    end
    if (LONG_TICKS < 1) begin : g_bad_long
        $error("button_channel: LONG_TICKS must be >= 1");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("button_channel: REPEAT_TICKS must be >= 1");
    end

    localparam int DW = cnt_width(DEBOUNCE_TICKS);
    localparam int HW = cnt_width(LONG_TICKS);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    logic [DW-1:0] db_cnt, db_cnt_n;
    logic          level_n, rise, fall;

    btn_state_e    state, state_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          press_n, release_n, long_n;

`ifdef AUTO_REPEAT_EN
    localparam int RW = cnt_width(REPEAT_TICKS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0] rep_cnt, rep_cnt_n;
    logic          repeat_n;
`endif

    // Any agreeing sample restarts the window, so only a run of
    // DEBOUNCE_TICKS disagreeing samples flips the level.
    always_comb begin
        level_n  = level;
        db_cnt_n = db_cnt;
        rise     = 1'b0;
        fall     = 1'b0;
        if (tick) begin
            if (s == level) begin
                db_cnt_n = '0;
            end else if (db_cnt == DB_LAST) begin
                level_n  = ~level;
                db_cnt_n = '0;
                rise     = ~level;
                fall     = level;
            end else begin
                db_cnt_n = db_cnt + DW'(1);
            end
        end
    end

    // A fall is checked first in each held state so it wins over an
    // expiring hold or repeat count on the same tick.
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        press_n    = 1'b0;
        release_n  = 1'b0;
        long_n     = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_n  = rep_cnt;
        repeat_n   = 1'b0;
`endif
        if (tick) begin
            case (state)
                RELEASED: begin
                    if (rise) begin
                        state_n    = PRESSED;
                        press_n    = 1'b1;
                        hold_cnt_n = '0;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state_n    = RELEASED;
                        release_n  = 1'b1;
                        hold_cnt_n = '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_n    = LONG;
                        long_n     = 1'b1;
                        hold_cnt_n = '0;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_n  = '0;
`endif
                    end else begin
                        hold_cnt_n = hold_cnt + HW'(1);
                    end
                end
                LONG: begin
                    if (fall) begin
                        state_n    = RELEASED;
                        release_n  = 1'b1;
                        hold_cnt_n = '0;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_n  = '0;
                    end else if (rep_cnt == REP_LAST) begin
                        repeat_n   = 1'b1;
                        rep_cnt_n  = '0;
                    end else begin
                        rep_cnt_n  = rep_cnt + RW'(1);
`endif
                    end
                end
                default: begin
                    state_n    = RELEASED;
                    hold_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level         <= 1'b0;
            db_cnt        <= '0;
            state         <= RELEASED;
            hold_cnt      <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            level         <= level_n;
            db_cnt        <= db_cnt_n;
            state         <= state_n;
            hold_cnt      <= hold_cnt_n;
            press         <= press_n;
            release_pulse <= release_n;
            long_press    <= long_n;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= rep_cnt_n;
            repeat_pulse <= repeat_n;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: rtl/synchronizer.sv
// WIDTH-wide two-flop synchronizer bringing asynchronous inputs into the
// clk domain. Both stages reset to 0.
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// N-channel pushbutton/switch conditioner: polarity fix, synchronizer, shared
// sample-tick prescaler and per-channel event channels. Optional: AUTO_REPEAT_EN.
module button_conditioner
    import input_pkg::*;
#(
    parameter int               WIDTH          = 4,
    parameter int               SAMPLE_CNT_MAX = 47500,
    parameter int               DEBOUNCE_TICKS = 200,
    parameter int               LONG_TICKS     = 2000,
    parameter int               REPEAT_TICKS   = 400,
    parameter logic [WIDTH-1:0] INVERT         = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           level,
    output logic [WIDTH-1:0]           press,
    output logic [WIDTH-1:0]           release_pulse,
    output logic [WIDTH-1:0]           long_press,
    output logic [WIDTH-1:0]           repeat_pulse,
    output logic [WIDTH*STATE_W-1:0]   fsm_state
);

    if (SAMPLE_CNT_MAX < 2) begin : g_bad_sample
        $error("button_conditioner: SAMPLE_CNT_MAX must be >= 2");
    end

    localparam int PW = cnt_width(SAMPLE_CNT_MAX - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_CNT_MAX - 1);

    logic [WIDTH-1:0] s;
    logic [PW-1:0]    pre_cnt;
    logic             tick;

    // Active-low lines are flipped before synchronising so a high idle line
    // already reads as released straight out of reset.
    synchronizer #(
        .WIDTH(WIDTH)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (in ^ INVERT),
        .q    (s)
    );

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        btn_state_e chan_state;

        button_channel #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .LONG_TICKS    (LONG_TICKS),
            .REPEAT_TICKS  (REPEAT_TICKS)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .s            (s[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .long_press   (long_press[i]),
            .repeat_pulse (repeat_pulse[i]),
            .state_dbg    (chan_state)
        );

        assign fsm_state[i*STATE_W +: STATE_W] = chan_state;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised N-channel input conditioner for pushbuttons and switches feeding the CPU clock domain. Per channel it synchronises, debounces with a shared sample-tick prescaler, and emits a clean level plus single-cycle press, release, long-press and optional auto-repeat pulses. It generalises the existing press-only debounce path, adding release and hold events and per-channel polarity.

## Interface
- WIDTH, 4, number of independent input channels
- SAMPLE_CNT_MAX, 47500, clk cycles per sample tick (500 us at 95 MHz); must be >= 2
- DEBOUNCE_TICKS, 200, consecutive disagreeing samples needed to flip a channel's level; must be >= 1
- LONG_TICKS, 2000, sample ticks of continuous press before long_press fires; must be >= 1
- REPEAT_TICKS, 400, sample ticks between auto-repeat pulses after long_press; must be >= 1
- INVERT, {WIDTH{1'b0}}, per-channel mask; a set bit treats that input as active-low
- clk  in  1  CPU clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in  in  WIDTH  raw asynchronous inputs
- level  out  WIDTH  debounced, polarity-corrected state; 1 = pressed
- press  out  WIDTH  one-cycle pulse when level rises
- release  out  WIDTH  one-cycle pulse when level falls
- long_press  out  WIDTH  one-cycle pulse after LONG_TICKS of continuous press
- repeat_pulse  out  WIDTH  one-cycle auto-repeat pulse; constant 0 when the feature is compiled out

## Operation
- Front end: `in ^ INVERT` passes through a 2-flop synchronizer to give `s[i]`.
- Prescaler: a shared counter runs 0 to SAMPLE_CNT_MAX-1 and wraps. `tick` is high for one cycle when the count equals SAMPLE_CNT_MAX-1. Nothing except the prescaler and synchronizer advances between ticks.
- Debounce, per channel, on each tick:
  - If `s[i] == level[i]`, clear `db_cnt`.
  - Otherwise, if `db_cnt == DEBOUNCE_TICKS-1`, toggle `level[i]` and clear `db_cnt`.
  - Otherwise, increment `db_cnt`.
- A single agreeing sample restarts the count, so glitches shorter than DEBOUNCE_TICKS samples are rejected.
- Per-channel FSM states: RELEASED, PRESSED, LONG.
  - RELEASED to PRESSED on level rise: press=1, clear hold_cnt.
  - PRESSED, each tick: increment hold_cnt. When hold_cnt reaches LONG_TICKS-1, go to LONG with long_press=1 and clear rep_cnt.
  - LONG, each tick: increment rep_cnt. When rep_cnt reaches REPEAT_TICKS-1, pulse repeat_pulse and clear rep_cnt (feature on only).
  - PRESSED or LONG to RELEASED on level fall: release=1, clear all counters.
- Simultaneous events: a level fall on the same tick that hold_cnt or rep_cnt would expire takes priority. release fires; long_press and repeat_pulse do not.
- Channels are fully independent. Any combination of channels may pulse in the same cycle.
- Counter widths are $clog2(max+1). Counters never wrap; they are bounded by the compare-and-clear above.

## Timing
- All outputs are registered. Reset values: level=0, press=release=long_press=repeat_pulse=0, FSM=RELEASED, all counters 0, synchronizer flops 0.
- Polarity at reset: a channel with INVERT set whose line idles high reads as released.
- Latency from an input edge to press or release: 2 synchronizer cycles, then the debounce window. The pulse lands on the DEBOUNCE_TICKS-th qualifying tick, one cycle after that tick.
- Pulses last exactly one clk cycle. level changes on the same edge that press or release asserts.
- Reset mid-operation: everything clears asynchronously. If the input is still asserted after reset, a new press is generated after a full debounce window.

## Configuration
- AUTO_REPEAT_EN defined: rep_cnt and repeat behaviour are present as described above.
- AUTO_REPEAT_EN undefined: no rep_cnt is instantiated, repeat_pulse is tied to 0, and the LONG state only waits for release.

## Structure
- Shared package `input_pkg`: FSM state enum (RELEASED, PRESSED, LONG) and a width helper for counters.
- Reuse the existing `synchronizer` module (WIDTH-wide) for the front end.
- One natural sub-module, `button_channel`: debounce counter, FSM and hold/repeat counters for one channel. It is instantiated WIDTH times via generate and fed the shared tick.

## Test plan
Bench parameters for all cases: SAMPLE_CNT_MAX=4, DEBOUNCE_TICKS=3, LONG_TICKS=5, REPEAT_TICKS=2, WIDTH=4.
- **Clean press/release:** hold in[0]=1 for 10 ticks, then 0 → press[0] pulses once, on the 3rd tick after the synchronised rise; release[0] pulses once, 3 ticks after the fall; level[0] follows.
- **Glitch rejection:** in[1] high for 2 ticks, low for 1 tick, repeated → level[1] stays 0 and no pulses.
- **Long press and repeat:** hold in[2] for 12 ticks after press → long_press[2] once, 5 ticks after press. With AUTO_REPEAT_EN, repeat_pulse[2] every 2 ticks thereafter; without it, repeat_pulse stays 0.
- **Polarity:** INVERT=4'b1000 with in[3] idling 1 → no press; driving in[3] to 0 gives press[3] after 3 ticks.
- **Reset and priority:** assert rst_n=0 while in LONG → all outputs 0 immediately. In a separate run, release timed to the long-expiry tick → release pulses and long_press does not.
